// File: rtl/switch_pkg.sv
// Shared types and helpers for the switch packet receiver.
package switch_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    DA,
    SA,
    LEN,
    PAYLOAD,
    PARITY,
    HOLD
  } rx_state_t;

  // One step of the running 8-bit XOR parity.
  function automatic logic [7:0] parity_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/switch_payload_buffer.sv
// Payload register file: synchronous write, combinational read, no data reset.
module switch_payload_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // Capture a payload byte when the receiver is in the payload phase.
  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/switch_packet_receiver.sv
// Receiver for the switch control byte stream: frames, checks and buffers
// one packet, then presents it to the core until it is accepted.
//
// Handshake: the packet on pkt_* / rd_data is held while pkt_valid=1; it is
// transferred on a posedge where pkt_valid=1 and pkt_ready=1. pkt_ready has
// no effect while pkt_valid=0, and the outputs never change while
// pkt_valid=1 and pkt_ready=0.
module switch_packet_receiver
  import switch_pkg::*;
#(
  parameter int MAX_PAYLOAD = 16,
  parameter int TIMEOUT     = 32,
  localparam int AW         = $clog2(MAX_PAYLOAD),
  localparam int TW         = $clog2(TIMEOUT + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    data_in,
  input  logic          sw_enable_in,
  output logic          read_out,
  output logic          pkt_valid,
  input  logic          pkt_ready,
  output logic [7:0]    pkt_da,
  output logic [7:0]    pkt_sa,
  output logic [7:0]    pkt_length,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          err_parity,
  output logic          err_length,
  output logic          err_timeout
);

  rx_state_t     state_q, state_d;
  logic [7:0]    da_q, da_d, sa_q, sa_d, len_q, len_d, acc_q, acc_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          err_par_q, err_par_d, err_len_q, err_len_d, err_to_q, err_to_d;
  logic          buf_we;

  // Next-state, field capture, parity accumulation and timeout decisions.
  always_comb begin
    state_d   = state_q;
    da_d      = da_q;
    sa_d      = sa_q;
    len_d     = len_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    idle_d    = '0;
    err_par_d = 1'b0;
    err_len_d = 1'b0;
    err_to_d  = 1'b0;
    buf_we    = 1'b0;

    // Idle counter only runs while a packet is being framed; HOLD is exempt.
    if (state_q inside {DA, SA, LEN, PAYLOAD, PARITY} && !sw_enable_in) begin
      if (idle_q == TW'(TIMEOUT - 1)) begin
        err_to_d = 1'b1;
        state_d  = IDLE;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (sw_enable_in && data_in == SYNC_BYTE) state_d = DA;
      end
      DA: begin
        if (sw_enable_in) begin
          da_d    = data_in;
          acc_d   = data_in;
          state_d = SA;
        end
      end
      SA: begin
        if (sw_enable_in) begin
          sa_d    = data_in;
          acc_d   = parity_fold(acc_q, data_in);
          state_d = LEN;
        end
      end
      LEN: begin
        if (sw_enable_in) begin
          len_d = data_in;
          acc_d = parity_fold(acc_q, data_in);
          cnt_d = '0;
          if (data_in == 8'd0) begin
            state_d = PARITY;
          end else if (data_in > 8'(MAX_PAYLOAD)) begin
            err_len_d = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (sw_enable_in) begin
          buf_we = 1'b1;
          acc_d  = parity_fold(acc_q, data_in);
          if (8'(cnt_q) == len_q - 8'd1) state_d = PARITY;
          else                           cnt_d   = cnt_q + AW'(1);
        end
      end
      PARITY: begin
        if (sw_enable_in) begin
          if (data_in == acc_q) begin
            state_d = HOLD;
          end else begin
            err_par_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      HOLD: begin
        if (pkt_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured fields, counters and registered error pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      da_q      <= '0;
      sa_q      <= '0;
      len_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      idle_q    <= '0;
      err_par_q <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      da_q      <= da_d;
      sa_q      <= sa_d;
      len_q     <= len_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      err_par_q <= err_par_d;
      err_len_q <= err_len_d;
      err_to_q  <= err_to_d;
    end
  end

  switch_payload_buffer #(.DEPTH(MAX_PAYLOAD), .AW(AW)) u_buf (
    .clock   (clock),
    .we      (buf_we),
    .wr_addr (cnt_q),
    .wr_data (data_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign read_out    = (state_q == IDLE);
  assign pkt_valid   = (state_q == HOLD);
  assign pkt_da      = da_q;
  assign pkt_sa      = sa_q;
  assign pkt_length  = len_q;
  assign err_parity  = err_par_q;
  assign err_length  = err_len_q;
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_switch_packet_receiver.sv
// Bench for switch_packet_receiver: transaction-level model of packet outcomes
// with a per-cycle compare process.
module tb_switch_packet_receiver;

  localparam int MAX_PAYLOAD = 16;
  localparam int TIMEOUT     = 32;
  localparam int AW          = 4;

  logic          clock, reset;
  logic [7:0]    data_in;
  logic          sw_enable_in;
  logic          read_out, pkt_valid, pkt_ready;
  logic [7:0]    pkt_da, pkt_sa, pkt_length, rd_data;
  logic [AW-1:0] rd_addr;
  logic          err_parity, err_length, err_timeout;

  switch_packet_receiver #(.MAX_PAYLOAD(MAX_PAYLOAD), .TIMEOUT(TIMEOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .sw_enable_in (sw_enable_in),
    .read_out     (read_out),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_da       (pkt_da),
    .pkt_sa       (pkt_sa),
    .pkt_length   (pkt_length),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .err_parity   (err_parity),
    .err_length   (err_length),
    .err_timeout  (err_timeout)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model / scoreboard ----------------
  typedef enum logic [1:0] {EV_GOOD, EV_PAR, EV_LEN, EV_TO} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] da, sa, len;
    logic [7:0] pl [MAX_PAYLOAD];
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Parity of a packet as the XOR of every header and payload byte.
  function automatic logic [7:0] model_parity(input ev_t e);
    logic [7:0] p;
    p = e.da ^ e.sa ^ e.len;
    for (int i = 0; i < MAX_PAYLOAD; i++)
      if (i < int'(e.len)) p = p ^ e.pl[i];
    return p;
  endfunction

  // Compare process: every error pulse and every held packet is matched
  // against the next expected outcome.
  ev_t  cur;
  logic prev_valid = 1'b0;
  logic prev_err   = 1'b0;
  always @(negedge clock) begin
    logic [2:0] errs;
    ev_t        e;
    logic [2:0] want;
    if (reset) begin
      prev_valid = 1'b0;
      prev_err   = 1'b0;
    end else begin
      errs = {err_parity, err_length, err_timeout};
      if (errs != 3'b000) begin
        check("err_onehot", $countones(errs), 1);
        check("err_one_cycle", prev_err, 1'b0);
        if (exp_q.size() == 0) begin
          check("unexpected_err", errs, 3'b000);
        end else begin
          e = exp_q.pop_front();
          case (e.kind)
            EV_PAR:  want = 3'b100;
            EV_LEN:  want = 3'b010;
            EV_TO:   want = 3'b001;
            default: want = 3'b000;
          endcase
          check("err_kind", errs, want);
        end
      end
      if (pkt_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", pkt_valid, 1'b0);
        end else begin
          cur = exp_q.pop_front();
          check("valid_kind", cur.kind, EV_GOOD);
        end
      end
      if (pkt_valid) begin
        check("pkt_da", pkt_da, cur.da);
        check("pkt_sa", pkt_sa, cur.sa);
        check("pkt_length", pkt_length, cur.len);
        check("read_out_in_hold", read_out, 1'b0);
        if (32'(rd_addr) < 32'(cur.len)) check("rd_data", rd_data, cur.pl[rd_addr]);
      end
      prev_valid = pkt_valid;
      prev_err   = |errs;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input logic en, input logic [7:0] d);
    sw_enable_in = en;
    data_in      = d;
    @(posedge clock);
    #1;
  endtask

  // Qualified byte, sometimes preceded by a few wait states.
  task automatic send(input logic [7:0] d);
    int w;
    w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    repeat (w) tick(1'b0, 8'($urandom));
    tick(1'b1, d);
  endtask

  // Traffic while idle: never a qualified sync byte; pkt_ready toggles freely.
  task automatic idle_junk(input int n);
    repeat (n) begin
      pkt_ready = 1'($urandom_range(0, 1));
      tick(1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)));
    end
    pkt_ready = 1'b0;
  endtask

  // Sends a packet (or a truncated one when stall_after>0) and checks the
  // edge on which its outcome appears.
  task automatic start_packet(input ev_t e, input logic [7:0] par, input int stall_after,
                              input int len_wait, output ev_kind_t k);
    logic [7:0] bq[$];
    int n;
    bq.push_back(8'hFF);
    bq.push_back(e.da);
    bq.push_back(e.sa);
    bq.push_back(e.len);
    if (int'(e.len) > MAX_PAYLOAD)  k = EV_LEN;
    else if (stall_after > 0)       k = EV_TO;
    else if (par == model_parity(e)) k = EV_GOOD;
    else                            k = EV_PAR;
    if (k != EV_LEN) begin
      for (int i = 0; i < int'(e.len); i++) bq.push_back(e.pl[i]);
      bq.push_back(par);
    end
    e.kind = k;
    exp_q.push_back(e);
    pkt_ready = 1'b0;
    check("idle_before_pkt", read_out, 1'b1);
    n = (k == EV_TO) ? stall_after : bq.size();
    for (int i = 0; i < n; i++) begin
      if (i == 3) repeat (len_wait) tick(1'b0, 8'($urandom));
      send(bq[i]);
    end
    case (k)
      EV_TO: begin
        repeat (TIMEOUT - 1) tick(1'b0, 8'($urandom));
        check("timeout_not_early", err_timeout, 1'b0);
        tick(1'b0, 8'($urandom));
        check("timeout_pulse", err_timeout, 1'b1);
      end
      EV_GOOD: check("valid_latency", pkt_valid, 1'b1);
      EV_PAR:  check("parity_pulse", {err_parity, err_length}, 2'b10);
      default: check("length_pulse", {err_parity, err_length}, 2'b01);
    endcase
    if (k != EV_GOOD) begin
      tick(1'b0, 8'($urandom));
      check("queue_drained_err", exp_q.size(), 0);
      check("idle_after_err", read_out, 1'b1);
      check("no_valid_after_err", pkt_valid, 1'b0);
    end
  endtask

  // Backpressure for hold_cycles, then accept the held packet.
  task automatic finish_hold(input int hold_cycles);
    for (int c = 0; c < hold_cycles; c++) begin
      pkt_ready = 1'b0;
      rd_addr   = AW'($urandom_range(0, MAX_PAYLOAD - 1));
      if ($urandom_range(0, 1) == 1) tick(1'b1, 8'hFF);
      else                           tick(1'b0, 8'($urandom));
    end
    check("still_valid_before_ready", pkt_valid, 1'b1);
    rd_addr   = AW'($urandom_range(0, MAX_PAYLOAD - 1));
    pkt_ready = 1'b1;
    tick(1'b0, 8'h00);
    pkt_ready = 1'b0;
    check("valid_drop", pkt_valid, 1'b0);
    check("read_out_after_xfer", read_out, 1'b1);
    check("queue_drained_good", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ev_t        e;
    ev_kind_t   k;
    int         mode, stall;
    logic [7:0] par;

    reset = 1'b1; data_in = '0; sw_enable_in = 1'b0; pkt_ready = 1'b0; rd_addr = '0;
    #1;
    check("rst_read_out", read_out, 1'b1);
    check("rst_pkt_valid", pkt_valid, 1'b0);
    check("rst_fields", {pkt_da, pkt_sa, pkt_length}, 24'h0);
    check("rst_errs", {err_parity, err_length, err_timeout}, 3'b000);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    tick(1'b0, 8'h00);

    // Good packet 12/34/2/AA,55 parity DB, accepted immediately.
    e.da = 8'h12; e.sa = 8'h34; e.len = 8'd2; e.pl[0] = 8'hAA; e.pl[1] = 8'h55;
    check("model_parity_pin_db", model_parity(e), 8'hDB);
    start_packet(e, 8'hDB, 0, 0, k);
    check("pin_da", pkt_da, 8'h12);
    check("pin_len", pkt_length, 8'd2);
    rd_addr = 4'd0; #1; check("pin_rd0", rd_data, 8'hAA);
    rd_addr = 4'd1; #1; check("pin_rd1", rd_data, 8'h55);
    finish_hold(0);

    // Zero-length packet.
    e.da = 8'h01; e.sa = 8'h02; e.len = 8'd0;
    check("model_parity_pin_03", model_parity(e), 8'h03);
    start_packet(e, 8'h03, 0, 0, k);
    check("pin_zero_len", pkt_length, 8'd0);
    finish_hold(1);

    // Bad parity on the first packet.
    e.da = 8'h12; e.sa = 8'h34; e.len = 8'd2; e.pl[0] = 8'hAA; e.pl[1] = 8'h55;
    start_packet(e, 8'hDA, 0, 0, k);
    check("pin_bad_parity_kind", k, EV_PAR);

    // Wait states before LEN, five cycles of backpressure with sync bytes in HOLD.
    start_packet(e, 8'hDB, 0, 3, k);
    finish_hold(5);

    // Oversized LEN.
    e.len = 8'd17;
    start_packet(e, 8'h00, 0, 0, k);
    check("pin_len_kind", k, EV_LEN);

    // Stall after SA.
    e.len = 8'd2;
    start_packet(e, 8'hDB, 3, 0, k);

    // Reset after one of two payload bytes.
    tick(1'b1, 8'hFF); tick(1'b1, 8'h12); tick(1'b1, 8'h34); tick(1'b1, 8'h02); tick(1'b1, 8'hAA);
    sw_enable_in = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_read_out", read_out, 1'b1);
    check("midrst_valid", pkt_valid, 1'b0);
    check("midrst_da", pkt_da, 8'h00);
    @(posedge clock);
    #1 reset = 1'b0;
    e.da = 8'h5A; e.sa = 8'hC3; e.len = 8'd2; e.pl[0] = 8'h0F; e.pl[1] = 8'hF0;
    start_packet(e, model_parity(e), 0, 0, k);
    finish_hold(2);

    // Randomised traffic.
    for (int p = 0; p < 60; p++) begin
      idle_junk($urandom_range(0, 3));
      e.da  = 8'($urandom);
      e.sa  = 8'($urandom);
      mode  = $urandom_range(0, 9);
      e.len = (mode == 0) ? 8'($urandom_range(MAX_PAYLOAD + 1, 255))
                          : 8'($urandom_range(0, MAX_PAYLOAD));
      for (int i = 0; i < MAX_PAYLOAD; i++) e.pl[i] = 8'($urandom);
      par   = model_parity(e);
      if (mode == 2) par = par ^ (8'd1 << $urandom_range(0, 7));
      stall = (mode == 1) ? int'($urandom_range(1, 4 + int'(e.len))) : 0;
      start_packet(e, par, stall, 0, k);
      if (k == EV_GOOD) finish_hold($urandom_range(0, 5));
    end

    idle_junk(4);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
